quant_part_regbank: RTL and testbench

Parametrised register bank whose per-entry security label is index-dependent: entry `i` carries label `{|i| LH dom[i]}`, with `dom[i]` held in a per-entry domain register. It generalises fixed two-entry quantified-label arrays to `DEPTH` entries of `WIDTH` bits. It adds a sequential reclaim engine that scrubs a range of entries before relabelling them, so no entry changes label while holding data. It sits between domain-tagged requesters and shared storage in the secure datapath.

---
 rtl/quant_part_regbank_if.sv | 33 +++
 rtl/quant_part_regbank.sv | 86 ++++++++
 tb/tb_quant_part_regbank.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/quant_part_regbank_if.sv
// quant_part_regbank_if: write, read and reclaim signals between requesters and the labelled register bank
interface quant_part_regbank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int IDXW = $clog2(DEPTH)
);
  logic wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic wr_dom;
  logic wr_err;
  logic rd_en;
  logic [IDXW-1:0] rd_idx;
  logic rd_req_dom;
  logic rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic rd_dom;
  logic rd_denied;
  logic rcl_req;
  logic [IDXW-1:0] rcl_base;
  logic [IDXW:0] rcl_count;
  logic rcl_dom;
  logic rcl_busy;
  logic rcl_done;
  modport master (
    output wr_en, wr_idx, wr_data, wr_dom, rd_en, rd_idx, rd_req_dom, rcl_req, rcl_base, rcl_count, rcl_dom,
    input wr_err, rd_valid, rd_data, rd_dom, rd_denied, rcl_busy, rcl_done
  );
  modport slave (
    input wr_en, wr_idx, wr_data, wr_dom, rd_en, rd_idx, rd_req_dom, rcl_req, rcl_base, rcl_count, rcl_dom,
    output wr_err, rd_valid, rd_data, rd_dom, rd_denied, rcl_busy, rcl_done
  );
endinterface

// File: rtl/quant_part_regbank.sv
// quant_part_regbank: register bank with per-entry domain labels and a scrub-then-relabel reclaim engine
// optional read guard (L may not read H) enabled by defining QUANT_READ_GUARD_EN
module quant_part_regbank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int IDXW = $clog2(DEPTH),
  parameter bit RESET_DOM = 1'b0
) (
  input logic clk,
  input logic reset,
  quant_part_regbank_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCRUB, RELABEL, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] data [DEPTH];
  logic dom [DEPTH];
  logic [IDXW-1:0] base;
  logic [IDXW:0] cnt, k, req_cnt;
  logic ndom, act, acc, wr_ok, rd_blk, guard;
  function automatic logic in_rng(logic [IDXW-1:0] idx, logic [IDXW-1:0] b, logic [IDXW:0] c);
    logic [IDXW-1:0] off;
    off = idx - b;
    return {1'b0, off} < c;
  endfunction
  assign req_cnt = bus.rcl_count > (IDXW+1)'(DEPTH) ? (IDXW+1)'(DEPTH) : bus.rcl_count;
  assign act = state == SCRUB || state == RELABEL;
  assign acc = state == IDLE && bus.rcl_req;
  // the range is blocked already in the accepting cycle, before base/count are latched
  assign wr_ok = bus.wr_en && bus.wr_dom == dom[bus.wr_idx]
    && !(act && in_rng(bus.wr_idx, base, cnt)) && !(acc && in_rng(bus.wr_idx, bus.rcl_base, req_cnt));
  assign rd_blk = (act && in_rng(bus.rd_idx, base, cnt)) || (acc && in_rng(bus.rd_idx, bus.rcl_base, req_cnt));
`ifdef QUANT_READ_GUARD_EN
  assign guard = bus.rd_req_dom < dom[bus.rd_idx];
`else
  assign guard = 1'b0;
`endif
  assign bus.rcl_busy = state != IDLE;
  assign bus.rcl_done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = acc ? (req_cnt == '0 ? RELABEL : SCRUB) : IDLE;
      SCRUB: state_n = k == cnt - (IDXW+1)'(1) ? RELABEL : SCRUB;
      RELABEL: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base <= '0;
      cnt <= '0;
      k <= '0;
      ndom <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
        dom[i] <= RESET_DOM;
      end
      bus.wr_err <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_dom <= 1'b0;
      bus.rd_denied <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        base <= bus.rcl_base;
        cnt <= req_cnt;
        ndom <= bus.rcl_dom;
        k <= '0;
      end
      if (wr_ok) data[bus.wr_idx] <= bus.wr_data;
      if (state == SCRUB) begin
        data[base + k[IDXW-1:0]] <= '0;
        k <= k + (IDXW+1)'(1);
      end
      for (int i = 0; i < DEPTH; i++)
        if (state == RELABEL && in_rng(IDXW'(i), base, cnt)) dom[i] <= ndom;
      bus.wr_err <= bus.wr_en && !wr_ok;
      bus.rd_valid <= bus.rd_en;
      bus.rd_data <= bus.rd_en && !rd_blk && !guard ? data[bus.rd_idx] : '0;
      bus.rd_dom <= bus.rd_en && dom[bus.rd_idx];
      bus.rd_denied <= bus.rd_en && (rd_blk || guard);
    end
  end
endmodule

// File: tb/tb_quant_part_regbank.sv
// tb_quant_part_regbank: directed checks of writes, reads, reclaim timing, saturation and mid-reclaim reset
module tb_quant_part_regbank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int n, dn;
  quant_part_regbank_if #(.WIDTH(8), .DEPTH(4)) bus();
  quant_part_regbank #(.WIDTH(8), .DEPTH(4), .RESET_DOM(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] idx, input logic [7:0] d, input logic dm);
    bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_data = d; bus.wr_dom = dm;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic rd(input logic [1:0] idx, input logic dm);
    bus.rd_en = 1'b1; bus.rd_idx = idx; bus.rd_req_dom = dm;
    tick();
    bus.rd_en = 1'b0;
  endtask
  task automatic rcl(input logic [1:0] b, input logic [2:0] c, input logic dm);
    bus.rcl_req = 1'b1; bus.rcl_base = b; bus.rcl_count = c; bus.rcl_dom = dm;
    tick();
    bus.rcl_req = 1'b0;
  endtask
  task automatic run_out(output int busy_n, output int done_n);
    busy_n = 0; done_n = 0;
    while (bus.rcl_busy && busy_n < 20) begin
      busy_n++;
      done_n += int'(bus.rcl_done);
      tick();
    end
  endtask
  initial begin
    bus.wr_en = 0; bus.wr_idx = 0; bus.wr_data = 0; bus.wr_dom = 0;
    bus.rd_en = 0; bus.rd_idx = 0; bus.rd_req_dom = 0;
    bus.rcl_req = 0; bus.rcl_base = 0; bus.rcl_count = 0; bus.rcl_dom = 0;
    tick(); tick();
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_dom", bus.rd_dom, 0);
    check("rst_rd_denied", bus.rd_denied, 0);
    check("rst_wr_err", bus.wr_err, 0);
    check("rst_busy", bus.rcl_busy, 0);
    check("rst_done", bus.rcl_done, 0);
    reset = 1'b0;
    wr(1, 8'hA5, 0);
    check("wr1_err", bus.wr_err, 0);
    rd(1, 0);
    check("rd1_valid", bus.rd_valid, 1);
    check("rd1_data", bus.rd_data, 8'hA5);
    check("rd1_dom", bus.rd_dom, 0);
    check("rd1_denied", bus.rd_denied, 0);
    tick();
    check("rd_valid_drop", bus.rd_valid, 0);
    wr(2, 8'h5A, 1);
    check("wr2_err", bus.wr_err, 1);
    tick();
    check("wr2_err_pulse", bus.wr_err, 0);
    rd(2, 0);
    check("rd2_data", bus.rd_data, 0);
    wr(0, 8'h11, 0); wr(3, 8'h33, 0); wr(2, 8'h22, 0);
    check("wr_setup_err", bus.wr_err, 0);
    rcl(3, 2, 1);
    n = 0; dn = 0;
    while (bus.rcl_busy && n < 20) begin
      n++;
      dn += int'(bus.rcl_done);
      bus.rcl_req = (n == 1); bus.rcl_base = 1; bus.rcl_count = 1; bus.rcl_dom = 1;
      bus.wr_en = (n == 1); bus.wr_idx = 0; bus.wr_data = 8'hFF; bus.wr_dom = 0;
      bus.rd_en = (n == 2); bus.rd_idx = 0; bus.rd_req_dom = 1;
      tick();
      bus.rcl_req = 0; bus.wr_en = 0; bus.rd_en = 0;
      if (n == 1) check("wr_in_range_err", bus.wr_err, 1);
      if (n == 2) begin
        check("rd_in_range_denied", bus.rd_denied, 1);
        check("rd_in_range_data", bus.rd_data, 0);
      end
    end
    check("rcl_busy_cycles", n, 4);
    check("rcl_done_cycles", dn, 1);
    tick();
    check("rcl_req_ignored", bus.rcl_busy, 0);
    rd(3, 1);
    check("rcl_e3_data", bus.rd_data, 0);
    check("rcl_e3_dom", bus.rd_dom, 1);
    rd(0, 1);
    check("rcl_e0_data", bus.rd_data, 0);
    check("rcl_e0_dom", bus.rd_dom, 1);
    rd(1, 0);
    check("rcl_e1_data", bus.rd_data, 8'hA5);
    check("rcl_e1_dom", bus.rd_dom, 0);
    rd(2, 0);
    check("rcl_e2_data", bus.rd_data, 8'h22);
    check("rcl_e2_dom", bus.rd_dom, 0);
    wr(0, 8'h3C, 1);
    check("wr_h_err", bus.wr_err, 0);
    rd(0, 0);
`ifdef QUANT_READ_GUARD_EN
    check("guard_data", bus.rd_data, 0);
    check("guard_denied", bus.rd_denied, 1);
`else
    check("guard_data", bus.rd_data, 8'h3C);
    check("guard_denied", bus.rd_denied, 0);
`endif
    check("guard_dom", bus.rd_dom, 1);
    rd(0, 1);
    check("h_read_data", bus.rd_data, 8'h3C);
    rcl(1, 0, 1);
    check("c0_busy", bus.rcl_busy, 1);
    check("c0_done_early", bus.rcl_done, 0);
    tick();
    check("c0_done", bus.rcl_done, 1);
    tick();
    check("c0_idle", bus.rcl_busy, 0);
    rd(1, 0);
    check("c0_e1_data", bus.rd_data, 8'hA5);
    check("c0_e1_dom", bus.rd_dom, 0);
    rcl(2, 7, 0);
    run_out(n, dn);
    check("sat_busy_cycles", n, 6);
    check("sat_done_cycles", dn, 1);
    rd(3, 0);
    check("sat_e3_dom", bus.rd_dom, 0);
    check("sat_e3_denied", bus.rd_denied, 0);
    rd(1, 0);
    check("sat_e1_data", bus.rd_data, 0);
    rd(0, 0);
    check("sat_e0_data", bus.rd_data, 0);
    check("sat_e0_dom", bus.rd_dom, 0);
    wr(2, 8'h77, 0);
    check("pre_rst_wr_err", bus.wr_err, 0);
    rcl(0, 4, 1);
    tick();
    check("mid_busy", bus.rcl_busy, 1);
    reset = 1'b1;
    tick();
    check("midrst_busy", bus.rcl_busy, 0);
    check("midrst_done", bus.rcl_done, 0);
    reset = 1'b0;
    tick();
    check("midrst_no_done", bus.rcl_done, 0);
    rd(2, 0);
    check("midrst_e2_data", bus.rd_data, 0);
    check("midrst_e2_dom", bus.rd_dom, 0);
    rd(0, 0);
    check("midrst_e0_dom", bus.rd_dom, 0);
    check("midrst_e0_denied", bus.rd_denied, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
